// File: rtl/branch_cmp_stage_pkg.sv
// Shared CPU definitions for the branch/compare stage: word width, compare/branch
// op encodings and the delay-slot FSM state encoding.
package branch_cmp_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_SLT  = 3'd0,
    OP_SLTU = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_BLEZ = 3'd4,
    OP_BGTZ = 3'd5,
    OP_BLTZ = 3'd6,
    OP_BGEZ = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SLOT = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  function automatic logic is_alu_op(op_e op);
    return (op == OP_SLT) || (op == OP_SLTU);
  endfunction

endpackage

// File: rtl/branch_cmp_stage_cmp_core.sv
// Purely combinational comparator shared by SLT/SLTU and all branch conditions.
module cmp_core
  import branch_cmp_stage_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  output logic            equal,
  output logic            less,
  output logic            a_zero,
  output logic            a_neg
);

  assign equal  = (a == b);
  assign a_zero = (a == '0);
  assign a_neg  = a[XLEN-1];

  // Inverting both sign bits maps two's complement order onto unsigned order.
  assign less = ({is_signed ^ a[XLEN-1], a[XLEN-2:0]} <
                 {is_signed ^ b[XLEN-1], b[XLEN-2:0]});

endmodule

// File: rtl/branch_cmp_stage.sv
// Single registered compare/branch stage with a delay-slot / wrong-path kill FSM
// keyed on the fetch epoch.
module branch_cmp_stage
  import branch_cmp_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_pc,
  input  logic [15:0]     in_imm,
  input  logic            in_epoch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_wb_en,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  op_e             op;
  state_e          state, state_next;
  logic            exp_epoch, epoch_next;
  logic            accept, pass, fire;
  logic            is_alu, cond, taken;
  logic            equal, less, a_zero, a_neg;
  logic [XLEN-1:0] target;

  assign op       = op_e'(in_op);
  assign is_alu   = is_alu_op(op);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  cmp_core u_cmp (
    .a         (in_a),
    .b         (in_b),
    .is_signed (op != OP_SLTU),
    .equal     (equal),
    .less      (less),
    .a_zero    (a_zero),
    .a_neg     (a_neg)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cond = 1'b0;
    unique case (op)
      OP_BEQ:  cond = equal;
      OP_BNE:  cond = !equal;
      OP_BLEZ: cond = a_neg || a_zero;
      OP_BGTZ: cond = !a_neg && !a_zero;
      OP_BLTZ: cond = a_neg;
      OP_BGEZ: cond = !a_neg;
      default: cond = 1'b0;
    endcase
  end

  assign taken  = cond && !is_alu;
  assign target = in_pc + XLEN'(4) + {{(XLEN-18){in_imm[15]}}, in_imm, 2'b00};

  // The delay slot passes unconditionally but never redirects; after it, only the
  // new epoch is allowed through.
  always_comb begin
    state_next = state;
    epoch_next = exp_epoch;
    pass       = 1'b0;
    fire       = 1'b0;
    if (accept) begin
      unique case (state)
        ST_RUN: begin
          pass = 1'b1;
          if (taken) begin
            fire       = 1'b1;
            state_next = ST_SLOT;
          end
        end
        ST_SLOT: begin
          pass       = 1'b1;
          epoch_next = !exp_epoch;
          state_next = ST_KILL;
        end
        ST_KILL: begin
          if (in_epoch == exp_epoch) begin
            pass       = 1'b1;
            fire       = taken;
            state_next = taken ? ST_SLOT : ST_RUN;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      exp_epoch <= 1'b0;
    end else begin
      state     <= state_next;
      exp_epoch <= epoch_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_wb_en   <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      if (accept)         out_valid <= pass;
      else if (out_ready) out_valid <= 1'b0;
      if (pass) begin
        out_result <= {{(XLEN-1){1'b0}}, is_alu && less};
        out_wb_en  <= is_alu;
      end
      redirect <= fire;
      if (fire) redirect_pc <= target;
    end
  end

endmodule
